// File: rtl/int_pin_conditioner.sv
// int_pin_conditioner
//   Conditions a PmodACL2 interrupt pin (INT1/INT2) after the two-flop
//   synchroniser: a stability filter qualifies the pin level, rise/fall pulses
//   mark changes of the filtered level, and sticky pending/overflow flags let
//   the SoC interrupt/status logic poll and clear.
//
// Parameters
//   FILTER_CYCLES  consecutive differing samples needed to accept a new level
//   CNT_W          qualify counter width
//   EDGE_SEL       active edge for pending: 0=rise, 1=fall, 2=both
//   INIT_LEVEL     filtered level loaded on reset
//
// Ports
//   C        in   clock, all logic on posedge
//   R        in   synchronous reset, active-high
//   D        in   synchronised pin level
//   enable   in   1 = active edges may set pending
//   clear    in   1-cycle strobe, clears pending and overflow
//   level    out  filtered pin level
//   rise     out  1-cycle pulse, filtered level 0->1
//   fall     out  1-cycle pulse, filtered level 1->0
//   pending  out  sticky: active edge seen while enabled
//   overflow out  sticky: active edge seen while pending already set
module int_pin_conditioner #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned EDGE_SEL      = 0,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic C,
  input  logic R,
  input  logic D,
  input  logic enable,
  input  logic clear,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pending,
  output logic overflow
);

  typedef enum logic {
    STABLE,
    QUALIFY
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  if ((FILTER_CYCLES == 0) ||
      (64'(FILTER_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_filter
    $error("int_pin_conditioner: FILTER_CYCLES=%0d outside 1..2**CNT_W-1",
           FILTER_CYCLES);
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             level_next;
  logic             rise_next, fall_next;
  logic             act_edge;
  logic             pending_next, overflow_next;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    unique case (state)
      STABLE: begin
        if (D != level) begin
          // A single-sample filter accepts the new level immediately.
          if (FILTER_CYCLES == 1) begin
            level_next = D;
          end else begin
            state_next = QUALIFY;
            cnt_next   = CNT_W'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end
      QUALIFY: begin
        if (D == level) begin
          state_next = STABLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          level_next = D;
          cnt_next   = '0;
          state_next = STABLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    rise_next = level_next & ~level;
    fall_next = ~level_next & level;

    case (EDGE_SEL)
      0:       act_edge = rise_next;
      1:       act_edge = fall_next;
      default: act_edge = rise_next | fall_next;
    endcase

    // A new edge beats a simultaneous clear for pending; overflow only
    // records an edge that landed on an already-pending flag not being cleared.
    pending_next = pending;
    if (act_edge && enable) begin
      pending_next = 1'b1;
    end else if (clear) begin
      pending_next = 1'b0;
    end

    overflow_next = overflow;
    if (act_edge && enable && pending && !clear) begin
      overflow_next = 1'b1;
    end else if (clear) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state    <= STABLE;
      cnt      <= '0;
      level    <= INIT_LEVEL;
      rise     <= 1'b0;
      fall     <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      level    <= level_next;
      rise     <= rise_next;
      fall     <= fall_next;
      pending  <= pending_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_int_pin_conditioner.sv
// Bench for int_pin_conditioner. Three instances share the inputs:
//   u0: FILTER_CYCLES=4, EDGE_SEL=0, INIT_LEVEL=0 (table-checked and modelled)
//   u1: FILTER_CYCLES=4, EDGE_SEL=2, INIT_LEVEL=0
//   u2: FILTER_CYCLES=1, EDGE_SEL=1, INIT_LEVEL=1
module tb_int_pin_conditioner;

  logic C = 1'b0;
  logic R = 1'b1;
  logic D = 1'b0;
  logic enable = 1'b1;
  logic clear = 1'b0;

  logic lvl [3];
  logic rs  [3];
  logic fl  [3];
  logic pd  [3];
  logic ov  [3];

  always #5 C = ~C;

  int_pin_conditioner #(.FILTER_CYCLES(4), .CNT_W(8), .EDGE_SEL(0), .INIT_LEVEL(1'b0)) u0 (
    .C(C), .R(R), .D(D), .enable(enable), .clear(clear),
    .level(lvl[0]), .rise(rs[0]), .fall(fl[0]), .pending(pd[0]), .overflow(ov[0])
  );
  int_pin_conditioner #(.FILTER_CYCLES(4), .CNT_W(8), .EDGE_SEL(2), .INIT_LEVEL(1'b0)) u1 (
    .C(C), .R(R), .D(D), .enable(enable), .clear(clear),
    .level(lvl[1]), .rise(rs[1]), .fall(fl[1]), .pending(pd[1]), .overflow(ov[1])
  );
  int_pin_conditioner #(.FILTER_CYCLES(1), .CNT_W(4), .EDGE_SEL(1), .INIT_LEVEL(1'b1)) u2 (
    .C(C), .R(R), .D(D), .enable(enable), .clear(clear),
    .level(lvl[2]), .rise(rs[2]), .fall(fl[2]), .pending(pd[2]), .overflow(ov[2])
  );

  localparam int unsigned M_FC [3] = '{4, 4, 1};
  localparam int unsigned M_ES [3] = '{0, 2, 1};
  localparam logic        M_IL [3] = '{1'b0, 1'b0, 1'b1};

  // Reference model: a new level is accepted once FILTER_CYCLES consecutive
  // samples disagree with the current level; run counts that disagreement.
  int unsigned m_run [3] = '{0, 0, 0};
  logic m_lvl [3] = '{1'b0, 1'b0, 1'b0};
  logic m_rs  [3] = '{1'b0, 1'b0, 1'b0};
  logic m_fl  [3] = '{1'b0, 1'b0, 1'b0};
  logic m_pd  [3] = '{1'b0, 1'b0, 1'b0};
  logic m_ov  [3] = '{1'b0, 1'b0, 1'b0};

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    int unsigned rep;
    logic        r, d, en, clr;
    logic [4:0]  exp;   // {level, rise, fall, pending, overflow} of u0
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    logic nr, nf, act;
    for (int i = 0; i < 3; i++) begin
      if (R) begin
        m_lvl[i] = M_IL[i];
        m_run[i] = 0;
        m_rs[i]  = 1'b0;
        m_fl[i]  = 1'b0;
        m_pd[i]  = 1'b0;
        m_ov[i]  = 1'b0;
      end else begin
        nr = 1'b0;
        nf = 1'b0;
        if (D != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] >= M_FC[i]) begin
            nr       = D;
            nf       = !D;
            m_lvl[i] = D;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        act = (M_ES[i] == 0) ? nr : (M_ES[i] == 1) ? nf : (nr | nf);
        if (act && enable && m_pd[i] && !clear) m_ov[i] = 1'b1;
        else if (clear) m_ov[i] = 1'b0;
        if (act && enable) m_pd[i] = 1'b1;
        else if (clear) m_pd[i] = 1'b0;
        m_rs[i] = nr;
        m_fl[i] = nf;
      end
    end
  endtask

  // One clock: inputs already driven, model steps on the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge C);
    model_update();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model u%0d.level", i),    lvl[i], m_lvl[i]);
      check($sformatf("model u%0d.rise", i),     rs[i],  m_rs[i]);
      check($sformatf("model u%0d.fall", i),     fl[i],  m_fl[i]);
      check($sformatf("model u%0d.pending", i),  pd[i],  m_pd[i]);
      check($sformatf("model u%0d.overflow", i), ov[i],  m_ov[i]);
      check($sformatf("model u%0d.rise_fall_excl", i), rs[i] & fl[i], 1'b0);
    end
  endtask

  function automatic void add(input int unsigned rep, input logic r, input logic d,
                              input logic en, input logic clr, input logic [4:0] exp);
    vec_t v;
    v.rep = rep; v.r = r; v.d = d; v.en = en; v.clr = clr; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    int unsigned hold;
    logic [4:0] got;

    // rep, R, D, en, clr, {level, rise, fall, pending, overflow}
    add(1, 1, 0, 1, 0, 5'b00000);  // reset
    add(3, 0, 1, 1, 0, 5'b00000);  // D=1 qualifying
    add(1, 0, 1, 1, 0, 5'b11010);  // accepted at k+3, rise, pending
    add(1, 0, 1, 1, 0, 5'b10010);  // rise drops
    add(3, 0, 0, 1, 0, 5'b10010);
    add(1, 0, 0, 1, 0, 5'b00110);  // fall does not touch pending on rise-only
    add(3, 0, 1, 1, 0, 5'b00010);  // three-sample glitch
    add(1, 0, 0, 1, 0, 5'b00010);  // rejected, no pulse
    add(3, 0, 1, 1, 0, 5'b00010);
    add(1, 0, 1, 1, 0, 5'b11011);  // second rise while pending -> overflow
    add(1, 0, 1, 1, 1, 5'b10000);  // clear both
    add(3, 0, 0, 1, 0, 5'b10000);
    add(1, 0, 0, 1, 0, 5'b00100);
    add(3, 0, 1, 1, 0, 5'b00000);
    add(1, 0, 1, 1, 1, 5'b11010);  // rise with clear: set wins, no overflow
    add(1, 0, 1, 1, 0, 5'b10010);
    add(1, 0, 1, 0, 1, 5'b10000);  // clear works while disabled
    add(3, 0, 0, 0, 0, 5'b10000);
    add(1, 0, 0, 0, 0, 5'b00100);
    add(3, 0, 1, 0, 0, 5'b00000);
    add(1, 0, 1, 0, 0, 5'b11000);  // rise pulses, pending stays 0
    add(3, 0, 0, 1, 0, 5'b10000);
    add(1, 0, 0, 1, 0, 5'b00100);
    add(2, 0, 1, 1, 0, 5'b00000);  // qualify in progress...
    add(1, 1, 1, 1, 0, 5'b00000);  // ...discarded by reset
    add(3, 0, 1, 1, 0, 5'b00000);
    add(1, 0, 1, 1, 0, 5'b11010);  // 4 edges after reset release
    add(3, 0, 0, 1, 0, 5'b10010);
    add(1, 0, 0, 1, 0, 5'b00110);
    add(3, 0, 1, 1, 0, 5'b00010);
    add(1, 0, 1, 1, 1, 5'b11010);  // pending+edge+clear: overflow stays 0

    foreach (vecs[n]) begin
      for (int unsigned k = 0; k < vecs[n].rep; k++) begin
        R = vecs[n].r; D = vecs[n].d; enable = vecs[n].en; clear = vecs[n].clr;
        step();
        got = {lvl[0], rs[0], fl[0], pd[0], ov[0]};
        check($sformatf("vec%0d.%0d u0 {lvl,rise,fall,pend,ovf}[4]", n, k), got[4], vecs[n].exp[4]);
        check($sformatf("vec%0d.%0d u0 rise", n, k),     got[3], vecs[n].exp[3]);
        check($sformatf("vec%0d.%0d u0 fall", n, k),     got[2], vecs[n].exp[2]);
        check($sformatf("vec%0d.%0d u0 pending", n, k),  got[1], vecs[n].exp[1]);
        check($sformatf("vec%0d.%0d u0 overflow", n, k), got[0], vecs[n].exp[0]);
      end
    end

    // EDGE_SEL=2 instance: a qualified falling edge sets pending.
    R = 1'b0; D = 1'b1; enable = 1'b1; clear = 1'b1;
    step();
    check("both u1 pending cleared", pd[1], 1'b0);
    clear = 1'b0; D = 1'b0;
    for (int k = 0; k < 3; k++) step();
    check("both u1 level held", lvl[1], 1'b1);
    check("both u1 pending before", pd[1], 1'b0);
    step();
    check("both u1 fall", fl[1], 1'b1);
    check("both u1 level", lvl[1], 1'b0);
    check("both u1 pending", pd[1], 1'b1);

    // Randomised stimulus, every instance checked against the model.
    hold = 0;
    for (int n = 0; n < 2000; n++) begin
      if (hold == 0) begin
        D    = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 6);
      end
      hold--;
      R      = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 3) != 0);
      clear  = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
